// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one radix-2 step per cycle, with a start/busy/done handshake.
module mul_div_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [2:0]   sel,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         flag
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic           busy_q, done_q, flag_q;
    logic [n-1:0]   result_q;
    logic [2*n-1:0] acc_q;      // {partial product | remainder, multiplier | quotient}
    logic [n-1:0]   opb_q;      // magnitude of B: multiplicand or divisor
    logic [2:0]     sel_q;
    logic           neg_q;
    logic [CW-1:0]  cnt_q;

    // Start-time decode: signedness, magnitudes, result sign and the skip-CALC cases.
    logic           is_div, a_signed, b_signed, a_neg, b_neg, neg_start, special;
    logic [n-1:0]   a_mag, b_mag, special_res;

    always_comb begin
        is_div      = sel[2];
        a_signed    = is_div ? ~sel[0] : (sel[1:0] == 2'b01 || sel[1:0] == 2'b10);
        b_signed    = is_div ? ~sel[0] : (sel[1:0] == 2'b01);
        a_neg       = a_signed & A[n-1];
        b_neg       = b_signed & B[n-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
        neg_start   = (is_div && sel[1]) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_res = '0;
        if (is_div && B == '0) begin
            special     = 1'b1;
            special_res = sel[1] ? A : '1;
        end else if (is_div && !sel[0] && A == {1'b1, {(n-1){1'b0}}} && B == '1) begin
            special     = 1'b1;
            special_res = sel[1] ? '0 : A;
        end
    end

    // One radix-2 step of either algorithm on the shared accumulator.
    logic [n:0]     mul_sum, rem_sh, diff;
    logic [2*n-1:0] acc_step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q[2*n-1:n], acc_q[n-1]};
        diff    = rem_sh - {1'b0, opb_q};
        if (sel_q[2])
            acc_step = diff[n] ? {rem_sh[n-1:0], acc_q[n-2:0], 1'b0}
                               : {diff[n-1:0],   acc_q[n-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc_q[n-1:1]};
    end

    // Sign correction and word selection once all n steps are done.
    logic [2*n-1:0] prod_fix;
    logic [n-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[n-1:0] : acc_q[n-1:0];
        rem_fix  = neg_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];
        if (sel_q[2])
            final_res = sel_q[1] ? rem_fix : quo_fix;
        else
            final_res = (sel_q[1:0] == 2'b00) ? prod_fix[n-1:0] : prod_fix[2*n-1:n];
    end

    // NOTE: every datapath register is reset too, so an abort leaves no partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b1;
            acc_q    <= '0;
            opb_q    <= '0;
            sel_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q  <= sel;
                        neg_q  <= neg_start;
                        acc_q  <= {{n{1'b0}}, a_mag};
                        opb_q  <= b_mag;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (special) begin
                            result_q <= special_res;
                            flag_q   <= (special_res == '0);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // n step edges, then one more edge to commit the sign-corrected result.
                    if (cnt_q == CW'(n)) begin
                        result_q <= final_res;
                        flag_q   <= (final_res == '0);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag   = flag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random operations against
// a plain-arithmetic reference model, and hand-written handshake/reset sequences.
module tb_mul_div_unit;

    logic        clk, rst_n, start;
    logic [31:0] A, B;
    logic [2:0]  sel;
    logic        busy, done, flag;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sel(sel),
        .busy(busy), .done(done), .result(result), .flag(flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_flag;
        int          exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions, using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'h0, a});
        longint      ub = longint'({32'h0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (s)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one operation, scramble the inputs after the start edge, watch the handshake.
    task automatic run_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic flg, output int busy_cyc,
                          output int done_cnt, output bit held);
        @(negedge clk);
        sel = s; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; sel = 3'($urandom);
        busy_cyc = 0; done_cnt = 0; res = '0; flg = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            if (done) begin
                done_cnt++;
                res = result;
                flg = flag;
            end
            @(negedge clk);
        end
        held = (result == res);
    endtask

    task automatic do_op(input string name, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_flag, input int exp_busy);
        logic [31:0] res;
        logic        flg;
        int          bc, dc;
        bit          held;
        run_op(s, a, b, res, flg, bc, dc, held);
        check({name, " result"}, 64'(res), 64'(exp_res));
        check({name, " flag"}, 64'(flg), 64'(exp_flag));
        check({name, " busy cycles"}, 64'(bc), 64'(exp_busy));
        check({name, " done pulses"}, 64'(dc), 64'd1);
        check({name, " result held"}, 64'(held), 64'd1);
    endtask

    task automatic wait_done(output bit ok);
        int i = 0;
        while (!done && i < 100) begin
            @(negedge clk);
            i++;
        end
        ok = done;
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0]  s;
        logic [31:0] a, b, exp;
        bit          ok, spec;

        vecs = '{
            '{3'd0, 32'd7,          32'd6,          32'h0000_002A, 1'b0, 34},
            '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 34},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, 34},
            '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 34},
            '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 34},
            '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 1'b0, 34},
            '{3'd2, 32'd2,          32'h8000_0000,  32'h0000_0001, 1'b0, 34},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, 34},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, 34},
            '{3'd5, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, 1'b0, 34},
            '{3'd7, 32'hFFFF_FFF9,  32'd2,          32'h0000_0001, 1'b0, 34},
            '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, 1},
            '{3'd7, 32'd5,          32'd0,          32'h0000_0005, 1'b0, 1},
            '{3'd4, 32'd7,          32'd0,          32'hFFFF_FFFF, 1'b0, 1},
            '{3'd6, 32'd0,          32'd0,          32'h0000_0000, 1'b1, 1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 1}
        };

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; sel = '0;
        repeat (3) @(negedge clk);
        check("reset busy",   64'(busy),   64'd0);
        check("reset done",   64'(done),   64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flag",   64'(flag),   64'd1);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                  vecs[i].exp_res, vecs[i].exp_flag, vecs[i].exp_busy);

        for (int i = 0; i < 150; i++) begin
            s = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 6)) - 32'd3; end
                default: ;
            endcase
            exp  = model(s, a, b);
            spec = s[2] && (b == 0 || (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            do_op($sformatf("rnd%0d sel%0d", i, s), s, a, b, exp, exp == 0, spec ? 1 : 34);
        end

        // Start and operand changes during CALC, start during DONE, start right after DONE.
        @(negedge clk);
        sel = 3'd0; A = 32'd7; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; A = 32'd100; B = 32'd100; sel = 3'd3;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        wait_done(ok);
        check("ignored start: done seen", 64'(ok), 64'd1);
        check("ignored start: result", 64'(result), 64'h2A);
        start = 1'b1; A = 32'd3; B = 32'd5; sel = 3'd0;
        @(negedge clk);
        check("start in DONE ignored", 64'(busy), 64'd0);
        check("result kept after DONE", 64'(result), 64'h2A);
        @(negedge clk);
        start = 1'b0;
        check("start after DONE accepted", 64'(busy), 64'd1);
        wait_done(ok);
        check("post-DONE op: done seen", 64'(ok), 64'd1);
        check("post-DONE op: result", 64'(result), 64'd15);
        @(negedge clk);

        // Asynchronous abort in the middle of CALC.
        @(negedge clk);
        sel = 3'd0; A = 32'd1234; B = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy",   64'(busy),   64'd0);
        check("abort done",   64'(done),   64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort flag",   64'(flag),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle after abort", 64'(busy), 64'd0);
        do_op("mul 3x3 after abort", 3'd0, 32'd3, 32'd3, 32'd9, 1'b0, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
